spi_sram_slave: RTL

SPI_SRAM_SLAVE -- requirements
Module: spi_sram_slave

---
 rtl/spi_sram_slave_if.sv | 28 ++
 rtl/spi_sram_slave.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_slave_if.sv
// Bus bundle between an SPI-to-SRAM slave and its environment.
// Carries the SPI pins (cs_n, mosi, miso), the SRAM port and the status outputs.
// The SCK clock and the rst reset are kept as plain ports on the module.
interface spi_sram_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic              sram_re;
    logic [DATA_W-1:0] sram_rdata;
    logic [7:0]        instr;
    logic              done;

    modport slave (
        input  cs_n, mosi, sram_rdata,
        output miso, sram_addr, sram_wdata, sram_we, sram_re, instr, done
    );

    modport master (
        output cs_n, mosi, sram_rdata,
        input  miso, sram_addr, sram_wdata, sram_we, sram_re, instr, done
    );
endinterface

// File: rtl/spi_sram_slave.sv
// SPI slave that bridges SPI read (0x03) and write (0x02) commands to a
// single-port SRAM. Frame layout: instruction byte, ADDR_W address bits, then
// data words. All bits are MSB first and are sampled on the rising edge of SCK.
// Optional build macro: SPI_SRAM_SEQ_MODE_EN enables sequential burst mode.
// In burst mode the address auto-increments and the transfer keeps running while cs_n stays low.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | cs_n high or waiting; the first low-cs_n edge takes instr bit 7
// INSTR    | shifting the remaining 7 instruction bits
// ADDR     | shifting ADDR_W address bits into sram_addr
// RD_FETCH | one cycle with sram_re high; rdata is loaded into the tx shifter
// RD_DATA  | driving the read word on miso, MSB first
// WR_DATA  | shifting a write word; sram_we is pulsed after the last bit
// IGNORE   | unsupported command or word finished; quiet until cs_n rises
module spi_sram_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic             SCK,
    input logic             rst,
    spi_sram_slave_if.slave bus
);

`ifdef SPI_SRAM_SEQ_MODE_EN
    localparam bit SeqMode = 1'b1;
`else
    localparam bit SeqMode = 1'b0;
`endif

    localparam int MaxBits = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                                : ((DATA_W > 8) ? DATA_W : 8);
    localparam int CntW    = $clog2(MaxBits + 1);
    localparam logic [7:0] RdCmd = 8'h03;
    localparam logic [7:0] WrCmd = 8'h02;

    typedef enum logic [2:0] {
        IDLE, INSTR, ADDR, RD_FETCH, RD_DATA, WR_DATA, IGNORE
    } stateType;

    stateType          state, nextState;
    logic [CntW-1:0]   bitCnt;
    logic [6:0]        instrShift;
    logic              isRead;
    logic [DATA_W-1:0] txShift;
    logic [DATA_W-1:0] rxShift;
    logic [DATA_W-1:0] sramWdata;
    logic [ADDR_W-1:0] sramAddr;
    logic              misoReg;
    logic              sramWe;
    logic [7:0]        instrReg;

    logic              sramRe;
    logic              rdDone;
    logic [7:0]        instrByte;
    logic              instrLast;
    logic              addrLast;
    logic              dataLast;
    logic              dataPenult;

    // State register; a synchronous reset returns the FSM to IDLE.
    always_ff @(posedge SCK) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state decode and the combinational strobes (sram_re and read done).
    always_comb begin
        nextState  = state;
        sramRe     = 1'b0;
        rdDone     = 1'b0;
        instrByte  = {instrShift, bus.mosi};
        instrLast  = (bitCnt == CntW'(6));
        addrLast   = (bitCnt == CntW'(ADDR_W - 1));
        dataLast   = (bitCnt == CntW'(DATA_W - 1));
        dataPenult = (bitCnt == CntW'(DATA_W - 2));
        case (state)
            IDLE:     nextState = INSTR;
            INSTR: begin
                if (instrLast)
                    nextState = (instrByte == RdCmd || instrByte == WrCmd) ? ADDR : IGNORE;
            end
            ADDR: begin
                if (addrLast) nextState = isRead ? RD_FETCH : WR_DATA;
            end
            RD_FETCH: begin
                sramRe    = 1'b1;
                nextState = RD_DATA;
            end
            RD_DATA: begin
                if (dataLast) begin
                    rdDone = 1'b1;
                    if (SeqMode) sramRe    = 1'b1;
                    else         nextState = IGNORE;
                end
            end
            // The write strobe cycle happens while still in WR_DATA.
            WR_DATA: begin
                if (sramWe && !SeqMode) nextState = IGNORE;
            end
            IGNORE:   nextState = IGNORE;
            default:  nextState = IDLE;
        endcase
        if (bus.cs_n) nextState = IDLE;
    end

    // Bit counter: restarts on every phase change and at each word boundary.
    always_ff @(posedge SCK) begin
        if (rst || bus.cs_n || (nextState != state))
            bitCnt <= '0;
        else if ((state == RD_DATA || state == WR_DATA) && dataLast)
            bitCnt <= '0;
        else if (state == INSTR || state == ADDR || state == RD_DATA || state == WR_DATA)
            bitCnt <= bitCnt + CntW'(1);
    end

    // Datapath: the shifters, the address, the write word, and the registered miso/we.
    always_ff @(posedge SCK) begin
        if (rst) begin
            instrShift <= '0;
            isRead     <= 1'b0;
            txShift    <= '0;
            rxShift    <= '0;
            sramWdata  <= '0;
            sramAddr   <= '0;
            misoReg    <= 1'b0;
            sramWe     <= 1'b0;
            instrReg   <= '0;
        end else if (bus.cs_n) begin
            instrShift <= '0;
            isRead     <= 1'b0;
            txShift    <= '0;
            rxShift    <= '0;
            sramWdata  <= '0;
            sramAddr   <= '0;
            misoReg    <= 1'b0;
            sramWe     <= 1'b0;
        end else begin
            misoReg <= 1'b0;
            sramWe  <= 1'b0;
            case (state)
                IDLE:  instrShift <= {6'b0, bus.mosi};
                INSTR: begin
                    instrShift <= {instrShift[5:0], bus.mosi};
                    if (instrLast) begin
                        instrReg <= instrByte;
                        isRead   <= (instrByte == RdCmd);
                    end
                end
                ADDR:  sramAddr <= ADDR_W'({sramAddr, bus.mosi});
                RD_FETCH: begin
                    txShift <= bus.sram_rdata << 1;
                    misoReg <= bus.sram_rdata[DATA_W-1];
                end
                RD_DATA: begin
                    if (dataLast) begin
                        // In burst mode the next word is fetched while the LSB goes out.
                        if (SeqMode) begin
                            txShift <= bus.sram_rdata << 1;
                            misoReg <= bus.sram_rdata[DATA_W-1];
                        end
                    end else begin
                        txShift <= txShift << 1;
                        misoReg <= txShift[DATA_W-1];
                    end
                    // Bump the address one cycle early so it is valid with the LSB-cycle sram_re.
                    if (SeqMode && dataPenult) sramAddr <= sramAddr + ADDR_W'(1);
                end
                WR_DATA: begin
                    rxShift <= DATA_W'({rxShift, bus.mosi});
                    if (dataLast && !(sramWe && !SeqMode)) begin
                        sramWdata <= DATA_W'({rxShift, bus.mosi});
                        sramWe    <= 1'b1;
                    end
                    if (SeqMode && sramWe) sramAddr <= sramAddr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.miso       = misoReg;
    assign bus.sram_addr  = sramAddr;
    assign bus.sram_wdata = sramWdata;
    assign bus.sram_we    = sramWe;
    assign bus.sram_re    = sramRe;
    assign bus.instr      = instrReg;
    assign bus.done       = rdDone | sramWe;

endmodule
